// File: rtl/subvq_score_collector.sv
// Frame score collector: buffers signed sub-VQ scores from a four-phase
// handshake, then streams the indices of scores within the beam of the best.
module subvq_score_collector #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [DATA_WIDTH-1:0]    i_n,
  input  logic [DATA_WIDTH-1:0]    i_beam,
  input  logic [DATA_WIDTH-1:0]    i_score,
  input  logic                     i_score_ready,
  output logic                     o_score_received,
  output logic [ADDRESS_WIDTH-1:0] o_sl_idx,
  output logic                     o_sl_valid,
  input  logic                     i_sl_accept,
  output logic [DATA_WIDTH-1:0]    o_sl_count,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [DW-1:0] L_DEPTH_DW = DW'(DEPTH);
  localparam logic [CW-1:0] L_DEPTH_CW = CW'(DEPTH);
  localparam logic [DW-1:0] L_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] L_MAX = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ACK,
    S_WAIT_DROP,
    S_THRESH,
    S_SCAN,
    S_EMIT,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_buf [DEPTH];

  logic [CW-1:0] r_n_eff;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_idx;
  logic [DW-1:0] r_beam;
  logic [DW-1:0] r_best;
  logic [DW-1:0] r_thr;
  logic [DW-1:0] r_sl_count;
  logic [AW-1:0] r_sl_idx;
  logic          r_sl_valid;
  logic          r_score_received;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0] w_n_clip;
  logic [CW-1:0] w_cnt_inc;
  logic [CW-1:0] w_idx_inc;
  logic [DW:0]   w_sum;
  logic          w_under;
  logic          w_over;
  logic [DW-1:0] w_thr;
  logic [DW-1:0] w_rd;
  logic          w_hit;
  logic          w_new_best;

  logic w_load;
  logic w_capture;
  logic w_inc_cnt;
  logic w_thr_ld;
  logic w_scan_step;
  logic w_emit_go;
  logic w_accept;

  assign w_n_clip  = (i_n >= L_DEPTH_DW) ? L_DEPTH_CW : i_n[CW-1:0];
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_idx_inc = r_idx + CW'(1);

  // Threshold is formed one bit wider so underflow can be detected and clamped.
  assign w_sum   = {r_best[DW-1], r_best} + {r_beam[DW-1], r_beam};
  assign w_under = w_sum[DW] & ~w_sum[DW-1];
  assign w_over  = ~w_sum[DW] & w_sum[DW-1];

  always_comb begin
    w_thr = w_sum[DW-1:0];
    unique case (1'b1)
      w_under: w_thr = L_MIN;
      w_over:  w_thr = L_MAX;
      default: w_thr = w_sum[DW-1:0];
    endcase
  end

  assign w_rd       = r_buf[r_idx[AW-1:0]];
  assign w_hit      = $signed(w_rd) >= $signed(r_thr);
  assign w_new_best = (r_cnt == '0) ||
                      ($signed(i_score) > $signed(r_best));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_inc_cnt   = 1'b0;
    w_thr_ld    = 1'b0;
    w_scan_step = 1'b0;
    w_emit_go   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          w_next = (w_n_clip == '0) ? S_FIN : S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (i_score_ready) begin
          w_capture = 1'b1;
          w_next    = S_ACK;
        end
      end
      S_ACK: begin
        w_inc_cnt = 1'b1;
        w_next    = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (!i_score_ready)
          w_next = (r_cnt == r_n_eff) ? S_THRESH : S_WAIT_RDY;
      end
      S_THRESH: begin
        w_thr_ld = 1'b1;
        w_next   = S_SCAN;
      end
      S_SCAN: begin
        if (w_hit) begin
          w_emit_go = 1'b1;
          w_next    = S_EMIT;
        end else begin
          w_scan_step = 1'b1;
          w_next = (w_idx_inc == r_n_eff) ? S_FIN : S_SCAN;
        end
      end
      S_EMIT: begin
        if (i_sl_accept) begin
          w_accept = 1'b1;
          w_next = (w_idx_inc == r_n_eff) ? S_FIN : S_SCAN;
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_capture) r_buf[r_cnt[AW-1:0]] <= i_score;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_n_eff          <= '0;
      r_beam           <= '0;
      r_cnt            <= '0;
      r_best           <= '0;
      r_thr            <= '0;
      r_idx            <= '0;
      r_sl_count       <= '0;
      r_sl_idx         <= '0;
      r_sl_valid       <= 1'b0;
      r_score_received <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      if (w_load) begin
        r_n_eff    <= w_n_clip;
        r_beam     <= i_beam;
        r_cnt      <= '0;
        r_best     <= '0;
        r_sl_count <= '0;
      end
      if (w_capture && w_new_best) r_best <= i_score;
      if (w_inc_cnt) r_cnt <= w_cnt_inc;
      if (w_thr_ld) begin
        r_thr <= w_thr;
        r_idx <= '0;
      end
      if (w_scan_step || w_accept) r_idx <= w_idx_inc;
      if (w_emit_go) r_sl_idx <= r_idx[AW-1:0];
      if (w_accept) r_sl_count <= r_sl_count + DW'(1);
      // Outputs are registered from the next state so they align with it.
      r_sl_valid       <= (w_next == S_EMIT);
      r_score_received <= (w_next == S_ACK) ||
                          (w_next == S_WAIT_DROP);
      r_busy           <= (w_next != S_IDLE) ||
                          (r_state == S_FIN);
      r_done           <= (r_state == S_FIN);
    end
  end

  assign o_score_received = r_score_received;
  assign o_sl_idx         = r_sl_idx;
  assign o_sl_valid       = r_sl_valid;
  assign o_sl_count       = r_sl_count;
  assign o_busy           = r_busy;
  assign o_done           = r_done;

endmodule

// File: doc/subvq_score_collector.md
# subvq_score_collector

Receiving end of the score handshake driven by `subvq_mgau_shortlist_top`. It accepts `n` signed Gaussian scores over the four-phase `score_ready`/`score_received` protocol and buffers them. It tracks the best score, then applies the beam (`threshold = best + beam`) and streams out the indices of every surviving Gaussian as the frame shortlist. It sits between the sub-VQ scorer and the downstream full-Gaussian evaluation stage.

## Interface
- `data_width`, 32, width of scores, `n`, `beam`, `sl_count`
- `address_width`, 8, buffer address width; capacity 2^address_width scores
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `n`  in  data_width  number of scores to collect, sampled at `start`
- `beam`  in  data_width  signed beam (≤0), sampled at `start`
- `score`  in  data_width  signed score from producer
- `score_ready`  in  1  producer asserts while `score` is valid
- `score_received`  out  1  collector acknowledge
- `sl_idx`  out  address_width  shortlist index (arrival order, 0-based)
- `sl_valid`  out  1  `sl_idx` valid
- `sl_accept`  in  1  downstream takes `sl_idx` when high with `sl_valid`
- `sl_count`  out  data_width  number of indices emitted this frame
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, WAIT_RDY, ACK, WAIT_DROP, THRESH, SCAN, EMIT, FIN.
- IDLE: on `start`, latch `n_eff = min(n, 2^address_width)`, latch `beam`, clear `cnt`, `best`, `sl_count`.
  - If `n_eff==0`, go to FIN.
  - Otherwise go to WAIT_RDY.
  - `start` outside IDLE is ignored.
- WAIT_RDY: when `score_ready==1`, write `score` to `buf[cnt]`.
  - If `cnt==0`, set `best=score`; otherwise set `best=max(best,score)`, signed compare.
  - Go to ACK.
- ACK: `score_received=1`; increment `cnt`; go to WAIT_DROP.
- WAIT_DROP: `score_received` stays 1 until `score_ready==0`, then drops.
  - If `cnt==n_eff`, go to THRESH; otherwise go to WAIT_RDY.
- THRESH: `thr = best + beam`, computed signed at data_width+1 bits, saturated to the most-negative data_width value on underflow. Clear `idx`; go to SCAN.
- SCAN: if `buf[idx] >= thr` (signed), present `idx` and go to EMIT.
  - Otherwise increment `idx`.
  - When `idx==n_eff`, go to FIN.
- EMIT: hold `sl_valid=1` with `sl_idx` stable until `sl_accept`.
  - On accept: increment `sl_count` and `idx`, then return to SCAN (or go to FIN if `idx` has reached `n_eff`).
- FIN: pulse `done` for one cycle; return to IDLE. `sl_count` holds until the next `start`.
- Ties: every score equal to `thr` is included. The best-score entry is always included.
- Scores beyond capacity are never requested, because the handshake stops after `n_eff`.

## Timing
- Reset values: `score_received=0`, `sl_valid=0`, `sl_idx=0`, `sl_count=0`, `busy=0`, `done=0`; state IDLE.
- `busy` is high from the cycle after `start` until the cycle `done` pulses, inclusive of the `done` cycle.
- Handshake, all outputs registered:
  - `score_ready` is sampled high in cycle k.
  - `score_received` is high from k+1.
  - `score_received` falls one cycle after `score_ready` is sampled low.
  - Minimum per score is 3 cycles plus producer latency.
- `score_ready` already high on entry to WAIT_RDY is accepted immediately. `score` is captured only in the WAIT_RDY sampling cycle.
- THRESH takes 1 cycle. SCAN takes 1 cycle per rejected entry.
- EMIT: `sl_valid` rises the cycle after the matching SCAN cycle. With `sl_accept` tied high, each emitted index costs 2 cycles.
- `done` asserts the cycle after the final SCAN/EMIT exit.
- `rst` mid-frame, including mid-handshake, immediately forces reset values. The producer must see `score_received` drop and restart.

## Test plan
- Reset: assert `rst` with `score_ready=1` → all outputs 0, `score_received` never rises.
- Basic frame: n=8, beam=-153503, scores {-200000, -50000, -300000, -120000, -203503, -210000, -60000, -90000}.
  - Best is -50000; thr is -203503.
  - Required stream: indices 0,1,3,4,6,7; `sl_count=6`; one `done` pulse.
- Handshake protocol: producer holds `score_ready` 5 cycles per score → exactly one capture per score; `score_received` follows the fall of `score_ready` by 1 cycle; `cnt` never double-increments.
- Boundaries:
  - n=0 → `done` 2 cycles after `start`, no `sl_valid`, `sl_count=0`.
  - n=300 → only 256 handshakes occur.
  - beam=0 with all scores equal → all indices emitted.
- Overflow and backpressure:
  - best=-2147483000, beam=-153503 → threshold saturates to 0x80000000 and all entries are emitted.
  - `sl_accept` low for 4 cycles → `sl_idx` stays stable and `sl_valid` stays high.
- Abort and restart: `rst` pulse after 3 of 8 scores → idle outputs. A subsequent `start` with n=3 completes correctly, and `start` pulses issued during that busy frame are ignored.
